// File: rtl/pid_ctrl_scheduler.sv
// pid_ctrl_scheduler
// Time-multiplexes one shared PID arithmetic unit across NUM_CH motor channels.
// On each control tick every channel is visited in order: enabled channels go
// through a start/done handshake with the PID unit, disabled or timed-out
// channels get their PID bank cleared and their duty forced to zero.
module pid_ctrl_scheduler #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_ena,
    input  logic [NUM_CH-1:0]          i_ch_en,
    input  logic [NUM_CH*DATA_W-1:0]   i_sp_in,
    input  logic [NUM_CH*DATA_W-1:0]   i_fb_in,
    output logic                       o_pid_start,
    output logic [CH_W-1:0]            o_pid_ch,
    output logic [DATA_W-1:0]          o_pid_sp,
    output logic [DATA_W-1:0]          o_pid_fb,
    output logic                       o_pid_clr,
    input  logic                       i_pid_done,
    input  logic [DATA_W-1:0]          i_pid_out,
    output logic [NUM_CH*DATA_W-1:0]   o_duty,
    output logic [NUM_CH-1:0]          o_dir,
    output logic [NUM_CH-1:0]          o_duty_valid,
    output logic                       o_busy,
    output logic                       o_overrun,
    output logic                       o_timeout_err
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_STORE,
        ST_NEXT
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [CNT_W-1:0]                r_cnt;
    logic [TMR_W-1:0]                r_timer;
    logic [CH_W-1:0]                 r_ch;
    logic [CH_W-1:0]                 r_pid_ch;
    logic [DATA_W-1:0]               r_pid_sp;
    logic [DATA_W-1:0]               r_pid_fb;
    logic                            r_pid_clr;
    logic [NUM_CH-1:0][DATA_W-1:0]   r_duty;
    logic [NUM_CH-1:0]               r_dir;
    logic [NUM_CH-1:0]               r_duty_valid;
    logic                            r_overrun;
    logic                            r_timeout_err;

    logic                            w_tick;
    logic                            w_ch_en_cur;
    logic                            w_first;
    logic                            w_advance;
    logic                            w_latch;
    logic                            w_skip;
    logic                            w_store;
    logic                            w_tmo;
    logic                            w_abort;
    logic [DATA_W-1:0]               w_abs;

    assign w_tick      = i_ena && (r_cnt == CNT_LAST);
    assign w_ch_en_cur = i_ch_en[r_ch];
    // Two's complement negate on DATA_W bits; the most negative value maps to
    // 2^(DATA_W-1), which is representable as an unsigned magnitude.
    assign w_abs       = i_pid_out[DATA_W-1] ? -i_pid_out : i_pid_out;

    // Control period counter; held at zero while disabled so a re-enable
    // restarts a full period.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_ena) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and per-cycle datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_first      = 1'b0;
        w_advance    = 1'b0;
        w_latch      = 1'b0;
        w_skip       = 1'b0;
        w_store      = 1'b0;
        w_tmo        = 1'b0;
        w_abort      = 1'b0;
        if (!i_ena) begin
            w_state_next = ST_IDLE;
            w_abort      = (r_state != ST_IDLE);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        w_first      = 1'b1;
                        w_state_next = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_ch_en_cur) begin
                        w_latch      = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_skip       = 1'b1;
                        w_state_next = ST_NEXT;
                    end
                end
                ST_START: begin
                    w_state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_pid_done) begin
                        w_store      = 1'b1;
                        w_state_next = ST_STORE;
                    end else if (r_timer == TMR_LAST) begin
                        w_tmo        = 1'b1;
                        w_state_next = ST_NEXT;
                    end
                end
                ST_STORE: begin
                    w_state_next = ST_NEXT;
                end
                ST_NEXT: begin
                    if (r_ch == CH_LAST) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_LOAD;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Channel index and PID wait timer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ch    <= '0;
            r_timer <= '0;
        end else begin
            if (w_abort || w_first) begin
                r_ch <= '0;
            end else if (w_advance) begin
                r_ch <= r_ch + CH_W'(1);
            end
            if (r_state == ST_START) begin
                r_timer <= '0;
            end else if (r_state == ST_WAIT && !i_pid_done) begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    // PID operand latch, clear pulse, duty/dir publication and sticky flags.
    // Duty is written on the WAIT->STORE edge so it is visible in the STORE
    // cycle, one cycle after pid_done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pid_ch      <= '0;
            r_pid_sp      <= '0;
            r_pid_fb      <= '0;
            r_pid_clr     <= 1'b0;
            r_duty        <= '0;
            r_dir         <= '0;
            r_duty_valid  <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_pid_clr    <= 1'b0;
            r_duty_valid <= '0;
            if (!i_ena) begin
                r_duty <= '0;
                r_dir  <= '0;
            end
            if (w_abort) begin
                r_pid_clr <= 1'b1;
                r_pid_ch  <= '0;
            end
            if (w_latch) begin
                r_pid_sp <= i_sp_in[int'(r_ch)*DATA_W +: DATA_W];
                r_pid_fb <= i_fb_in[int'(r_ch)*DATA_W +: DATA_W];
                r_pid_ch <= r_ch;
            end
            if (w_skip || w_tmo) begin
                r_pid_clr          <= 1'b1;
                r_pid_ch           <= r_ch;
                r_duty[r_ch]       <= '0;
                r_dir[r_ch]        <= 1'b0;
                r_duty_valid[r_ch] <= 1'b1;
            end
            if (w_store) begin
                r_duty[r_ch]       <= w_abs;
                r_dir[r_ch]        <= i_pid_out[DATA_W-1];
                r_duty_valid[r_ch] <= 1'b1;
            end
            if (w_tick && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
            end
            if (w_tmo) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_pid_start   = (r_state == ST_START);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_pid_ch      = r_pid_ch;
    assign o_pid_sp      = r_pid_sp;
    assign o_pid_fb      = r_pid_fb;
    assign o_pid_clr     = r_pid_clr;
    assign o_duty        = r_duty;
    assign o_dir         = r_dir;
    assign o_duty_valid  = r_duty_valid;
    assign o_overrun     = r_overrun;
    assign o_timeout_err = r_timeout_err;

endmodule
